// File: rtl/t08_arb_pkg.sv
// t08 memory arbiter shared types.
// FSM states, grant owner, bus constants.
package t08_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_D
  } grant_t;

  localparam logic [3:0] SEL_WORD = 4'hF;

  localparam int STREAK_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 255;

  // D wins ties until the streak limit is hit
  function automatic grant_t pick_grant(
    input logic if_req,
    input logic d_req,
    input logic streak_full
  );
    grant_t g;
    g = GNT_NONE;
    unique case (1'b1)
      (d_req && !(if_req && streak_full)):  g = GNT_D;
      (if_req && (!d_req || streak_full)):  g = GNT_IF;
      default:                              g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/t08_mem_arbiter.sv
// Two-way (fetch / data) arbiter for the t08 memory bus.
// Moves whole words; one transaction in flight at a time.
module t08_mem_arbiter
  import t08_arb_pkg::*;
#(
  parameter int STREAK_MAX = STREAK_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata
);

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  grant_t        grant;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;
  logic          bus_we;

  grant_t        pick;
  logic          streak_full;
  logic          expire;
  logic          finish;
  logic [SW-1:0] streak_inc;
  logic [31:0]   resp_word;

  always_comb begin
    streak_full = (streak == SW'(STREAK_MAX));
    pick        = pick_grant(if_req, d_req, streak_full);
    expire      = (timer == TW'(TIMEOUT - 1));
    finish      = mem_done || expire;
    streak_inc  = streak_full ? streak : streak + SW'(1);
    // stores and timeouts return zero
    resp_word   = (mem_done && !bus_we) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= GNT_NONE;
      streak    <= '0;
      timer     <= '0;
      bus_we    <= 1'b0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick == GNT_IF) begin
            grant     <= GNT_IF;
            state     <= ISSUE;
            timer     <= '0;
            streak    <= '0;
            bus_we    <= 1'b0;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_sel   <= SEL_WORD;
          end else if (pick == GNT_D) begin
            grant     <= GNT_D;
            state     <= ISSUE;
            timer     <= '0;
            streak    <= if_req ? streak_inc : '0;
            bus_we    <= d_we;
            mem_read  <= !d_we;
            mem_write <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_sel   <= d_sel;
          end
        end
        ISSUE, WAIT: begin
          if (finish) begin
            state     <= RESP;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            err       <= !mem_done;
            if (grant == GNT_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= resp_word;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= resp_word;
            end
          end else begin
            timer <= timer + TW'(1);
            if (state == ISSUE && mem_busy) begin
              state     <= WAIT;
              mem_read  <= 1'b0;
              mem_write <= 1'b0;
            end
          end
        end
        RESP: begin
          state  <= IDLE;
          grant  <= GNT_NONE;
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/t08_mem_arbiter.md
Name: t08_mem_arbiter

Overview:
- Shares the single t08 memory bus between two requesters: instruction fetch (IF) and data load/store (D).
- Drives the bus read/write strobes and the busy/done handshake, and returns the raw 32-bit word plus a one-cycle ack to the winner.
- Sits between the fetch/handler logic and the memory bus interface.
- Byte/half extraction and sign extension by func3 stay in t08_handler; this block moves whole words only.

Parameters:
- STREAK_MAX, 4: maximum consecutive D grants while if_req is pending; the next grant is forced to IF.
- TIMEOUT, 255: cycles allowed in ISSUE+WAIT before the transaction is aborted with err.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  32  fetch address
- if_ack  out  1  one-cycle completion pulse to IF
- if_rdata  out  32  fetched word, valid in if_ack cycle
- d_req  in  1  data request; held with other d_* until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_sel  in  4  byte enables for store
- d_ack  out  1  one-cycle completion pulse to D
- d_rdata  out  32  loaded word, valid in d_ack cycle
- err  out  1  high with ack when transaction timed out
- mem_read  out  1  bus read strobe
- mem_write  out  1  bus write strobe
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_sel  out  4  bus byte enables
- mem_busy  in  1  bus accepted request
- mem_done  in  1  bus completed request (pulse)
- mem_rdata  in  32  bus read data, valid with mem_done

Behaviour:
- Reset: state=IDLE, grant=NONE, streak=0, timer=0. All outputs 0 (strobes, acks, err, mem_addr/wdata/sel, if_rdata, d_rdata).
- All outputs are registered.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: arbitration on sampled requests.
  - d_req only: grant D.
  - if_req only: grant IF.
  - Both: grant D unless streak==STREAK_MAX, then grant IF.
  - Latch addr/wdata/sel/we of the winner into bus regs and go to ISSUE.
  - IF grant forces read, sel=4'hF, wdata=0.
  - mem_done in IDLE is ignored.
- Streak counter:
  - Increments on a D grant while if_req=1.
  - Clears on any IF grant, or on a D grant with if_req=0.
  - Saturates at STREAK_MAX.
- ISSUE:
  - mem_read or mem_write held high, bus regs stable.
  - mem_busy=1: next state WAIT, strobe drops.
  - mem_done=1 (with or without busy): capture mem_rdata, go to RESP.
- WAIT: strobes low, bus regs stable; mem_done=1 captures mem_rdata and goes to RESP.
- Timer:
  - Clears on entering ISSUE and counts each ISSUE/WAIT cycle.
  - At TIMEOUT, go to RESP with err pending; strobes drop and rdata is 0.
  - A mem_done in the expiry cycle wins (normal completion, no err).
- RESP: exactly one cycle.
  - Granted requester's ack=1; its rdata shows the captured word (0 for stores).
  - err=1 only on timeout.
  - rdata outputs hold until the next capture.
  - Next state IDLE.
- Requester contract: drop req on the edge it samples ack. A req still high in IDLE starts a new transaction.
- Latency: req sampled in IDLE at edge N gives strobe high from N+1. If mem_busy and mem_done are both high at N+1, ack is high during cycle N+2 to N+3. Otherwise ack is 1 cycle after mem_done is sampled.
- Reset mid-transaction: returns to IDLE next edge, strobes drop, no ack issued, late mem_done ignored.
- Never more than one transaction outstanding. Requests arriving during ISSUE/WAIT/RESP wait for IDLE.

Decomposition:
- t08_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - grant enum (GNT_NONE, GNT_IF, GNT_D)
  - SEL_WORD=4'hF
  - default STREAK_MAX/TIMEOUT constants
- Single flat module. The arbitration and timer are too small to justify a sub-module.

Test Plan:
- IF read: if_req, if_addr=0x100; bus busy at +1, done at +3 with rdata 0x00A00093 -> mem_addr=0x100, mem_sel=F, if_ack one cycle, if_rdata=0x00A00093, err=0.
- D store: d_we=1, d_addr=12, d_wdata=0x7FFFFFFF, d_sel=4'b0011 -> mem_write high until busy, mem_addr=12, mem_sel=3; d_ack after done, d_rdata=0.
- Simultaneous if_req and d_req, D re-requesting every time (STREAK_MAX=4) -> grants D,D,D,D,IF; streak returns to 0.
- Timeout: d_req load, mem_busy=1, mem_done never (TIMEOUT=8) -> d_ack with err=1 and d_rdata=0 exactly 8 cycles after ISSUE entry; mem_read low afterwards.
- Done without busy: mem_done=1 in the first ISSUE cycle with rdata 0xFFFFFFFF -> goes straight to RESP, if_rdata=0xFFFFFFFF.
- rst=1 during WAIT, then mem_done pulse after release -> state IDLE, no ack, outputs 0; the late done is ignored.
